weight_loader: RTL and testbench
================================

Name: weight_loader

Overview:
Consumes 256-bit weight words from the byte-concatenation bridge after the flash reader and writes them into the per-layer LeNet-5 weight buffers (conv1, conv2, fc1, fc2, fc3) in flash order. It tracks which layer is being filled and the word address within that layer, and signals per-layer and overall completion to the top-level controller. The input follows the bridge protocol: in_data becomes valid one cycle after the in_en pulse.

Parameters:
DATA_W, 256, word width (32 weight bytes)
ADDR_W, 11, write address width per layer buffer
L0_WORDS, 5, conv1 words (150 B)
L1_WORDS, 75, conv2 words (2400 B)
L2_WORDS, 1500, fc1 words (48000 B)
L3_WORDS, 315, fc2 words (10080 B)
L4_WORDS, 27, fc3 words (840 B, last word zero-padded)

Ports:
sys_clk  in  1  clock; one clock domain
sys_rst  in  1  asynchronous, active-high reset
load_start  in  1  one-cycle pulse that starts a full weight load
in_en  in  1  word strobe from the bridge
in_data  in  DATA_W  word; valid in the cycle after in_en
busy  out  1  high from start until the load completes
wr_en  out  1  buffer write strobe
wr_layer  out  3  target layer, 0..4
wr_addr  out  ADDR_W  word address within the layer
wr_data  out  DATA_W  word to write
layer_done  out  1  one-cycle pulse with the last write of each layer
load_done  out  1  level; set at completion, cleared by the next load_start
ovf_err  out  1  sticky; in_en seen while not busy; cleared by load_start

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, en_d 0.
- en_d is a one-cycle registered copy of in_en. When en_d=1 and FSM=LOAD, in_data is captured.
- Writes are registered: in_en at cycle t -> wr_en=1 at t+2, with wr_layer/wr_addr/wr_data for that word. Latency 2, throughput 1 word/cycle. Back-to-back in_en pulses are supported.
- FSM states:
  - IDLE: load_start -> LOAD; sets busy, clears load_done and ovf_err, layer=0, addr=0.
  - LOAD: each captured word writes at (layer, addr), then addr++.
    - If addr==Lk_WORDS-1: layer_done pulses with that wr_en, addr returns to 0, layer++.
    - On the last word of layer 4: go to DONE (or CHECK when the optional feature is enabled).
  - DONE: busy=0, load_done=1. Next cycle -> IDLE, with load_done held.
- The word-count limit for each layer is selected from the parameters by the layer index. Comparisons are ADDR_W wide. Each parameter must be ≤ 2^ADDR_W; an elaboration check enforces this.
- load_start while busy: ignored, no restart.
- en_d while not in LOAD: word dropped, no write, ovf_err set.
- load_start in the same cycle as en_d in IDLE: start is taken, the word is dropped, and ovf_err stays clear (the clear has priority).
- Reset mid-load: immediate return to IDLE. Partial buffer contents are invalid. load_done=0.

Optional Feature:
Macro WEIGHT_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR over all DATA_W words is kept and cleared by load_start.
  - After fc3, FSM enters CHECK and expects exactly one extra word that is not written to any buffer.
  - If that word ≠ the XOR, sticky output csum_err (1 bit, reset 0, cleared by load_start) is set. The FSM then goes to DONE.
- Not defined: no CHECK state and no csum_err port. DONE follows the last fc3 word directly.

Decomposition:
- Package weight_loader_pkg:
  - FSM state enum {IDLE, LOAD, CHECK, DONE}
  - layer index constants LAYER_CONV1..LAYER_FC3 (3-bit)
  - NUM_LAYERS=5
  - default word-count constants
- One sub-module, wl_addr_gen: the layer/address counter with per-layer limit select. Inputs: step, clear. Outputs: layer, addr, layer_last, all_last.
- The top holds the FSM, the en_d/capture stage, the output registers and the error flags.

Test Plan:
- Params 2,1,3,1,1. load_start, then 8 in_en pulses 4 cycles apart with data 0x01..0x08 -> writes (0,0,01),(0,1,02),(1,0,03),(2,0..2,04..06),(3,0,07),(4,0,08). layer_done on 02,03,06,07,08. load_done=1 two cycles after the last wr_en; busy=0.
- Same params with 8 back-to-back in_en -> 8 consecutive wr_en cycles, first at start+2, same addresses as above.
- in_en in IDLE with data 0xAA -> no wr_en, ovf_err=1. Next load_start -> ovf_err=0.
- Assert sys_rst after 3 words -> busy=0, wr_en=0, load_done=0 immediately. A new load then restarts at layer 0, addr 0.
- load_start pulsed again mid-load -> ignored; addresses continue without a jump.
- WEIGHT_LOADER_CHECKSUM_EN, params 1,1,1,1,1, data 1,2,4,8,16, then 0x1F -> csum_err=0. Repeat with 0x1E -> csum_err=1. Neither checksum word produces a wr_en.

Source files
------------

// File: rtl/weight_loader_pkg.sv
// Shared types and defaults for the LeNet-5 weight loader.
// Optional checksum stage is enabled with WEIGHT_LOADER_CHECKSUM_EN.
package weight_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE
    } state_e;

    localparam logic [2:0] LAYER_CONV1 = 3'd0;
    localparam logic [2:0] LAYER_CONV2 = 3'd1;
    localparam logic [2:0] LAYER_FC1   = 3'd2;
    localparam logic [2:0] LAYER_FC2   = 3'd3;
    localparam logic [2:0] LAYER_FC3   = 3'd4;

    localparam int NUM_LAYERS = 5;

    localparam int DEF_DATA_W   = 256;
    localparam int DEF_ADDR_W   = 11;
    localparam int DEF_L0_WORDS = 5;
    localparam int DEF_L1_WORDS = 75;
    localparam int DEF_L2_WORDS = 1500;
    localparam int DEF_L3_WORDS = 315;
    localparam int DEF_L4_WORDS = 27;

endpackage

// File: rtl/weight_loader_addr_gen.sv
// Layer / word-address counter with per-layer word limit.
// Walks conv1..fc3 in order, wrapping to layer 0 after fc3.
module wl_addr_gen
    import weight_loader_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int L0_WORDS = DEF_L0_WORDS,
    parameter int L1_WORDS = DEF_L1_WORDS,
    parameter int L2_WORDS = DEF_L2_WORDS,
    parameter int L3_WORDS = DEF_L3_WORDS,
    parameter int L4_WORDS = DEF_L4_WORDS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              step_i,
    output logic [2:0]        layer_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              layer_last_o,
    output logic              all_last_o
);

    localparam int MAX_WORDS = 2 ** ADDR_W;

    if (L0_WORDS < 1 || L0_WORDS > MAX_WORDS ||
        L1_WORDS < 1 || L1_WORDS > MAX_WORDS ||
        L2_WORDS < 1 || L2_WORDS > MAX_WORDS ||
        L3_WORDS < 1 || L3_WORDS > MAX_WORDS ||
        L4_WORDS < 1 || L4_WORDS > MAX_WORDS) begin : g_bad_cfg
        $error("wl_addr_gen: layer word count outside 1..2**ADDR_W");
    end

    localparam logic [ADDR_W-1:0] LAST0 = ADDR_W'(L0_WORDS - 1);
    localparam logic [ADDR_W-1:0] LAST1 = ADDR_W'(L1_WORDS - 1);
    localparam logic [ADDR_W-1:0] LAST2 = ADDR_W'(L2_WORDS - 1);
    localparam logic [ADDR_W-1:0] LAST3 = ADDR_W'(L3_WORDS - 1);
    localparam logic [ADDR_W-1:0] LAST4 = ADDR_W'(L4_WORDS - 1);

    logic [2:0]        layer_q, layer_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_addr;
    logic              layer_last;
    logic              all_last;

    always_comb begin
        last_addr = '0;
        case (layer_q)
            LAYER_CONV1: last_addr = LAST0;
            LAYER_CONV2: last_addr = LAST1;
            LAYER_FC1:   last_addr = LAST2;
            LAYER_FC2:   last_addr = LAST3;
            LAYER_FC3:   last_addr = LAST4;
            default:     last_addr = '0;
        endcase
    end

    assign layer_last = (addr_q == last_addr);
    assign all_last   = layer_last && (layer_q == LAYER_FC3);

    always_comb begin
        layer_d = layer_q;
        addr_d  = addr_q;
        if (clear_i) begin
            layer_d = LAYER_CONV1;
            addr_d  = '0;
        end else if (step_i) begin
            if (layer_last) begin
                addr_d  = '0;
                layer_d = all_last ? LAYER_CONV1 : layer_q + 3'd1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            layer_q <= LAYER_CONV1;
            addr_q  <= '0;
        end else begin
            layer_q <= layer_d;
            addr_q  <= addr_d;
        end
    end

    assign layer_o      = layer_q;
    assign addr_o       = addr_q;
    assign layer_last_o = layer_last;
    assign all_last_o   = all_last;

endmodule

// File: rtl/weight_loader.sv
// Writes bridge words into the five LeNet-5 weight buffers in flash order.
// WEIGHT_LOADER_CHECKSUM_EN adds a trailing XOR check word and csum_err.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int L0_WORDS = DEF_L0_WORDS,
    parameter int L1_WORDS = DEF_L1_WORDS,
    parameter int L2_WORDS = DEF_L2_WORDS,
    parameter int L3_WORDS = DEF_L3_WORDS,
    parameter int L4_WORDS = DEF_L4_WORDS
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              load_start,
    input  logic              in_en,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              wr_en,
    output logic [2:0]        wr_layer,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              layer_done,
    output logic              load_done,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    output logic              csum_err,
`endif
    output logic              ovf_err
);

    state_e            state_q, state_d;
    logic              en_q;
    logic              take;
    logic              step;
    logic              drop;
    logic [2:0]        layer;
    logic [ADDR_W-1:0] addr;
    logic              layer_last;
    logic              all_last;

    logic              wr_en_q, wr_en_d;
    logic [2:0]        wr_layer_q, wr_layer_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              layer_done_q, layer_done_d;
    logic              load_done_q, load_done_d;
    logic              ovf_q, ovf_d;

    assign take = load_start && (state_q == IDLE);
    assign step = en_q && (state_q == LOAD);
    assign drop = en_q && (state_q != LOAD) && (state_q != CHECK);

    wl_addr_gen #(
        .ADDR_W  (ADDR_W),
        .L0_WORDS(L0_WORDS),
        .L1_WORDS(L1_WORDS),
        .L2_WORDS(L2_WORDS),
        .L3_WORDS(L3_WORDS),
        .L4_WORDS(L4_WORDS)
    ) u_addr_gen (
        .clk_i       (sys_clk),
        .rst_i       (sys_rst),
        .clear_i     (take),
        .step_i      (step),
        .layer_o     (layer),
        .addr_o      (addr),
        .layer_last_o(layer_last),
        .all_last_o  (all_last)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (load_start) state_d = LOAD;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            LOAD:  if (step && all_last) state_d = CHECK;
            CHECK: if (en_q) state_d = DONE;
`else
            LOAD:  if (step && all_last) state_d = DONE;
            CHECK: state_d = IDLE;
`endif
            DONE:  state_d = IDLE;
        endcase
    end

    // The start clear outranks any error or done flag raised the same cycle.
    always_comb begin
        busy         = (state_q == LOAD) || (state_q == CHECK);
        wr_en_d      = step;
        wr_layer_d   = step ? layer : wr_layer_q;
        wr_addr_d    = step ? addr : wr_addr_q;
        wr_data_d    = step ? in_data : wr_data_q;
        layer_done_d = step && layer_last;
        load_done_d  = load_done_q;
        ovf_d        = ovf_q;
        if (take) begin
            load_done_d = 1'b0;
            ovf_d       = 1'b0;
        end else begin
            if (state_q == DONE) load_done_d = 1'b1;
            if (drop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            en_q         <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_layer_q   <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            layer_done_q <= 1'b0;
            load_done_q  <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            en_q         <= in_en;
            wr_en_q      <= wr_en_d;
            wr_layer_q   <= wr_layer_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            layer_done_q <= layer_done_d;
            load_done_q  <= load_done_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              csum_err_q, csum_err_d;

    always_comb begin
        csum_d     = csum_q;
        csum_err_d = csum_err_q;
        if (take) begin
            csum_d     = '0;
            csum_err_d = 1'b0;
        end else begin
            if (step) csum_d = csum_q ^ in_data;
            if (en_q && (state_q == CHECK) && (in_data != csum_q))
                csum_err_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            csum_q     <= '0;
            csum_err_q <= 1'b0;
        end else begin
            csum_q     <= csum_d;
            csum_err_q <= csum_err_d;
        end
    end

    assign csum_err = csum_err_q;
`endif

    assign wr_en      = wr_en_q;
    assign wr_layer   = wr_layer_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign layer_done = layer_done_q;
    assign load_done  = load_done_q;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed table-driven bench for weight_loader (layer sizes 2,1,3,1,1).
// With WEIGHT_LOADER_CHECKSUM_EN a second all-ones instance checks csum_err.
module tb_weight_loader;

    localparam int DW = 256;
    localparam int AW = 11;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    localparam int NW = 9;
`else
    localparam int NW = 8;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic          in_en = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic          busy, wr_en, layer_done, load_done, ovf_err;
    logic [2:0]    wr_layer;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    always #5 clk = ~clk;

    weight_loader #(
        .DATA_W(DW), .ADDR_W(AW),
        .L0_WORDS(2), .L1_WORDS(1), .L2_WORDS(3),
        .L3_WORDS(1), .L4_WORDS(1)
    ) dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .load_start(load_start),
        .in_en     (in_en),
        .in_data   (in_data),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_layer  (wr_layer),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .layer_done(layer_done),
        .load_done (load_done),
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        .csum_err  (csum_err),
`endif
        .ovf_err   (ovf_err)
    );

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic          csum_err;
    logic          c_busy, c_wr_en, c_layer_done, c_load_done, c_ovf_err;
    logic          c_csum_err;
    logic [2:0]    c_wr_layer;
    logic [AW-1:0] c_wr_addr;
    logic [DW-1:0] c_wr_data;
    int            c_wr = 0;

    weight_loader #(
        .DATA_W(DW), .ADDR_W(AW),
        .L0_WORDS(1), .L1_WORDS(1), .L2_WORDS(1),
        .L3_WORDS(1), .L4_WORDS(1)
    ) dut_c (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .load_start(load_start),
        .in_en     (in_en),
        .in_data   (in_data),
        .busy      (c_busy),
        .wr_en     (c_wr_en),
        .wr_layer  (c_wr_layer),
        .wr_addr   (c_wr_addr),
        .wr_data   (c_wr_data),
        .layer_done(c_layer_done),
        .load_done (c_load_done),
        .csum_err  (c_csum_err),
        .ovf_err   (c_ovf_err)
    );

    always @(negedge clk) if (c_wr_en) c_wr++;
`endif

    typedef struct {
        logic [2:0]    layer;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          ld;
        int            cyc;
    } wr_t;

    wr_t           exp_t [8];
    wr_t           got_q [$];
    logic [DW-1:0] words [9];
    int            cyc = 0;
    int            start_cyc = 0;
    int            lastw = -100;
    logic          ld2 = 1'b0;
    logic          bz2 = 1'b1;
    int            n_tests = 0;
    int            n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        wr_t w;
        if (cyc == lastw + 2) begin
            ld2 = load_done;
            bz2 = busy;
        end
        if (wr_en) begin
            w.layer = wr_layer;
            w.addr  = wr_addr;
            w.data  = wr_data;
            w.ld    = layer_done;
            w.cyc   = cyc;
            got_q.push_back(w);
            lastw = cyc;
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n, input int gap, input bit st,
                          input int base, input int tail);
        for (int c = 0; c < n * gap + tail; c++) begin
            if (c == 0) start_cyc = cyc;
            if (st && c == 1) chk("busy after start", {255'd0, busy}, 1);
            load_start = st && (c == 0);
            in_en = (c % gap == 0) && (c / gap < n);
            if (c > 0 && ((c - 1) % gap == 0) && ((c - 1) / gap < n))
                in_data = words[base + (c - 1) / gap];
            else
                in_data = '0;
            tick();
        end
        load_start = 1'b0;
        in_en      = 1'b0;
        in_data    = '0;
    endtask

    task automatic check_writes(input string nm, input int n,
                                input bit timing, input int gap);
        chk({nm, " count"}, DW'(got_q.size()), DW'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            chk($sformatf("%s[%0d] layer", nm, i),
                DW'(got_q[i].layer), DW'(exp_t[i].layer));
            chk($sformatf("%s[%0d] addr", nm, i),
                DW'(got_q[i].addr), DW'(exp_t[i].addr));
            chk($sformatf("%s[%0d] data", nm, i),
                got_q[i].data, exp_t[i].data);
            chk($sformatf("%s[%0d] layer_done", nm, i),
                DW'(got_q[i].ld), DW'(exp_t[i].ld));
            if (timing)
                chk($sformatf("%s[%0d] cycle", nm, i),
                    DW'(got_q[i].cyc), DW'(start_cyc + i * gap + 2));
        end
    endtask

    initial begin
        exp_t[0] = '{3'd0, 11'd0, 256'h01, 1'b0, 0};
        exp_t[1] = '{3'd0, 11'd1, 256'h02, 1'b1, 0};
        exp_t[2] = '{3'd1, 11'd0, 256'h03, 1'b1, 0};
        exp_t[3] = '{3'd2, 11'd0, 256'h04, 1'b0, 0};
        exp_t[4] = '{3'd2, 11'd1, 256'h05, 1'b0, 0};
        exp_t[5] = '{3'd2, 11'd2, 256'h06, 1'b1, 0};
        exp_t[6] = '{3'd3, 11'd0, 256'h07, 1'b1, 0};
        exp_t[7] = '{3'd4, 11'd0, 256'h08, 1'b1, 0};
        for (int i = 0; i < 8; i++) words[i] = DW'(i + 1);
        words[8] = 256'h08;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs",
            {251'd0, busy, wr_en, layer_done, load_done, ovf_err}, '0);
        rst = 1'b0;
        tick();

        // spaced pulses, 4 cycles apart
        got_q.delete();
        stream(NW, 4, 1'b1, 0, 6);
        check_writes("spaced", 8, 1'b1, 4);
`ifndef WEIGHT_LOADER_CHECKSUM_EN
        chk("load_done at last_wr+2", {255'd0, ld2}, 1);
        chk("busy at last_wr+2", {255'd0, bz2}, 0);
`else
        chk("csum_err good sum", {255'd0, csum_err}, 0);
`endif
        chk("load_done after spaced", {255'd0, load_done}, 1);
        chk("busy after spaced", {255'd0, busy}, 0);

        // in_en while idle
        got_q.delete();
        in_en = 1'b1;
        tick();
        in_en   = 1'b0;
        in_data = 256'hAA;
        tick();
        in_data = '0;
        repeat (3) tick();
        chk("idle word writes", DW'(got_q.size()), 0);
        chk("ovf_err set", {255'd0, ovf_err}, 1);
        chk("load_done held", {255'd0, load_done}, 1);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("ovf_err cleared", {255'd0, ovf_err}, 0);
        chk("load_done cleared", {255'd0, load_done}, 0);
        chk("busy after restart", {255'd0, busy}, 1);

        // reset in the middle of a load, while a write is on the bus
        stream(3, 1, 1'b0, 0, 1);
        chk("pre-reset wr_en", {255'd0, wr_en}, 1);
        chk("pre-reset wr_layer", DW'(wr_layer), 1);
        #1 rst = 1'b1;
        #1;
        chk("mid-load reset outputs",
            {253'd0, busy, wr_en, load_done}, '0);
        check_writes("partial", 2, 1'b0, 1);
        tick();
        rst = 1'b0;
        tick();

        // back-to-back words after reset
        got_q.delete();
        stream(NW, 1, 1'b1, 0, 4);
        check_writes("b2b", 8, 1'b1, 1);
`ifndef WEIGHT_LOADER_CHECKSUM_EN
        chk("b2b load_done at last_wr+2", {255'd0, ld2}, 1);
`endif
        chk("b2b load_done", {255'd0, load_done}, 1);
        chk("b2b busy", {255'd0, busy}, 0);

        // load_start pulsed again mid-load
        got_q.delete();
        stream(3, 1, 1'b1, 0, 2);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        stream(NW - 3, 1, 1'b0, 3, 4);
        check_writes("restart ignored", 8, 1'b0, 1);
        chk("restart ignored load_done", {255'd0, load_done}, 1);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
        begin : csum_tests
            int base_wr;
            words[0] = 256'h01;
            words[1] = 256'h02;
            words[2] = 256'h04;
            words[3] = 256'h08;
            words[4] = 256'h10;
            words[5] = 256'h1F;
            base_wr = c_wr;
            stream(6, 1, 1'b1, 0, 4);
            chk("csum good writes", DW'(c_wr - base_wr), 5);
            chk("csum good err", {255'd0, c_csum_err}, 0);
            chk("csum good done", {255'd0, c_load_done}, 1);
            words[5] = 256'h1E;
            base_wr = c_wr;
            stream(6, 1, 1'b1, 0, 4);
            chk("csum bad writes", DW'(c_wr - base_wr), 5);
            chk("csum bad err", {255'd0, c_csum_err}, 1);
            chk("csum bad done", {255'd0, c_load_done}, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
